// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: shares one RS232 byte serializer between NREQ requesters (round-robin + lock)
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req, req_data, lock per-requester request level, byte lanes [8i+7:8i], ownership hold
//   grant, owner        one-cycle one-hot grant pulse, index of last granted requester
//   tx_start, tx_data   one-cycle start strobe and held byte to the serializer
//   tx_busy             serializer busy for the whole frame
//   busy, timeout_err   arbiter not idle, one-cycle pulse when tx_busy never rose
module rs232_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int GAP_CYCLES = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   lock,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        owner,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              timeout_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  localparam int CMAX = ACK_TIMEOUT > GAP_CYCLES ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NREQ-1:0] grant_n;
  logic [2:0] owner_n, pick;
  logic [7:0] data_n, pick_data;
  logic start_n, terr_n, locked;
  int best, d;
  // d is the round-robin distance from owner+1, so the last owner ranks last
  always_comb begin
    pick = owner;
    pick_data = tx_data;
    locked = 1'b0;
    best = NREQ;
    d = 0;
    for (int i = 0; i < NREQ; i++)
      if (i == int'(owner) && lock[i] && req[i]) begin
        locked = 1'b1;
        pick = 3'(i);
        pick_data = req_data[8*i +: 8];
      end
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(owner) - 1;
      if (d < 0) d += NREQ;
      if (!locked && req[i] && d < best) begin
        best = d;
        pick = 3'(i);
        pick_data = req_data[8*i +: 8];
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    owner_n = owner;
    grant_n = '0;
    data_n = tx_data;
    start_n = 1'b0;
    terr_n = 1'b0;
    case (state)
      IDLE: if (|req) begin
        grant_n = NREQ'(1) << pick;
        owner_n = pick;
        data_n = pick_data;
        state_n = ISSUE;
      end
      ISSUE: begin
        start_n = 1'b1;
        cnt_n = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_n = WAIT_DONE;
        else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          terr_n = 1'b1;
          cnt_n = '0;
          state_n = GAP;
        end else cnt_n = cnt + 1'b1;
      WAIT_DONE: if (!tx_busy) begin
        cnt_n = '0;
        state_n = GAP;
      end
      GAP: if (GAP_CYCLES == 0 || cnt == CW'(GAP_CYCLES - 1)) state_n = IDLE;
        else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 3'(NREQ - 1);
      grant <= '0;
      tx_data <= 8'h00;
      tx_start <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      owner <= owner_n;
      grant <= grant_n;
      tx_data <= data_n;
      tx_start <= start_n;
      timeout_err <= terr_n;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb_rs232_tx_arbiter: scoreboard bench for rs232_tx_arbiter with a simple serializer model
module tb_rs232_tx_arbiter;
  localparam int NREQ = 4, GAP = 16, ACK = 64, FRAME = 10;
  typedef struct {int idx; logic [7:0] data;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, no_ack = 1'b0;
  logic [NREQ-1:0] req = '0, lock = '0, grant, grant_prev = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [2:0] owner;
  logic [7:0] tx_data;
  logic tx_start, tx_busy, busy, timeout_err, prev_txb = 1'b0, prev_busy = 1'b0;
  int total = 0, bad = 0, cyc = 0, bcnt = 0;
  int n_grant = 0, n_g2 = 0, n_start = 0, n_terr = 0;
  int start_cyc = 0, terr_cyc = 0, fall_cyc = 0, idle_cyc = 0, g2_before, s_before;
  exp_t sb[$];
  exp_t e;
  rs232_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .lock(lock),
    .grant(grant), .owner(owner), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (tx_start && !no_ack) bcnt <= FRAME;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  assign tx_busy = bcnt != 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int idx, input logic [7:0] data);
    exp_t x;
    x.idx = idx;
    x.data = data;
    sb.push_back(x);
  endtask
  task automatic wait_grants(input int target);
    for (int i = 0; i < 500 && n_grant < target; i++) begin @(negedge clk); #1; end
    if (n_grant < target) chk("grant_wait", n_grant, target);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) begin @(negedge clk); #1; end
    if (busy) chk("idle_wait", busy, 0);
  endtask
  task automatic wait_txbusy();
    for (int i = 0; i < 100 && !tx_busy; i++) begin @(negedge clk); #1; end
    if (!tx_busy) chk("txbusy_wait", tx_busy, 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_owner"}, owner, NREQ - 1);
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (|grant) begin
        n_grant++;
        if (grant[2]) n_g2++;
      end
      if (tx_start) begin
        start_cyc = cyc;
        n_start++;
        if (sb.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("tx_data", tx_data, e.data);
          chk("owner", owner, e.idx);
          chk("grant_prev", grant_prev, 32'(1) << e.idx);
          chk("grant_pulse", grant, 0);
        end
      end
      if (timeout_err) begin
        n_terr++;
        terr_cyc = cyc;
      end
      if (prev_txb && !tx_busy) fall_cyc = cyc;
      if (prev_busy && !busy) idle_cyc = cyc;
    end
    grant_prev = grant;
    prev_txb = tx_busy;
    prev_busy = busy;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) push(i % NREQ, 8'h10 + 8'(i % NREQ));
    req = 4'b1111;
    wait_grants(5);
    req = '0;
    wait_idle();
    req_data = {24'h0, 8'hA5};
    push(0, 8'hA5);
    req = 4'b0001;
    wait_grants(6);
    req = '0;
    wait_idle();
    chk("gap_len", idle_cyc - fall_cyc, GAP + 1);
    chk("hold_data", tx_data, 8'hA5);
    req_data = {8'h00, 8'h22, 8'h21, 8'h00};
    push(1, 8'h21);
    push(1, 8'h21);
    push(1, 8'h21);
    push(2, 8'h22);
    lock = 4'b0010;
    req = 4'b0110;
    wait_grants(9);
    lock = '0;
    wait_grants(10);
    req = '0;
    wait_idle();
    no_ack = 1'b1;
    req_data = {8'h33, 16'h0, 8'h44};
    push(3, 8'h33);
    push(0, 8'h44);
    req = 4'b1001;
    wait_grants(11);
    req = 4'b0001;
    for (int i = 0; i < 200 && n_terr < 1; i++) begin @(negedge clk); #1; end
    chk("timeout_lat", terr_cyc - start_cyc, ACK);
    no_ack = 1'b0;
    wait_grants(12);
    req = '0;
    wait_idle();
    req_data = {16'h0, 8'h55, 8'h0};
    push(1, 8'h55);
    req = 4'b0010;
    wait_grants(13);
    req = '0;
    wait_txbusy();
    s_before = n_start;
    g2_before = n_g2;
    req = 4'b0100;
    repeat (3) @(negedge clk);
    #1;
    req = '0;
    wait_idle();
    repeat (5) @(negedge clk);
    #1;
    chk("withdraw_grant2", n_g2, g2_before);
    chk("withdraw_start", n_start, s_before);
    req_data = {8'h66, 24'h0};
    push(3, 8'h66);
    req = 4'b1000;
    wait_grants(14);
    req = '0;
    wait_txbusy();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 50 && tx_busy; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    req_data = {8'h73, 8'h72, 8'h71, 8'h70};
    push(0, 8'h70);
    req = 4'b1111;
    wait_grants(15);
    req = '0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("terr_count", n_terr, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
